// File: rtl/pe_sched_pkg.sv
// Shared types and constants for the PE scheduler/arbiter.
// Holds the FSM state encoding, PE opcode constants and a width helper.
package pe_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } sched_state_e;

  // opcode_func = {funct7, opcode class}; zero-extended onto the DATA_W opcode bus
  localparam logic [11:0] OP_ADD = {7'b0000001, 5'b00001};
  localparam logic [11:0] OP_SUB = {7'b0000010, 5'b00001};
  localparam logic [11:0] OP_MUL = {7'b0000011, 5'b00001};

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pe_sched_arbiter_if.sv
// Requester command/response channels plus the PE-side issue/result signals.
// The arbiter uses the slave view; the environment (requesters + PE) uses master.
interface pe_sched_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_opcode;
  logic [NUM_REQ*DATA_W-1:0] req_op1;
  logic [NUM_REQ*DATA_W-1:0] req_op2;
  logic [NUM_REQ*DATA_W-1:0] req_op3;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_error;
  logic [DATA_W-1:0]         pe_opcode_func;
  logic [DATA_W-1:0]         pe_op1;
  logic [DATA_W-1:0]         pe_op2;
  logic [DATA_W-1:0]         pe_op3;
  logic                      pe_valid_in;
  logic [DATA_W-1:0]         pe_result_out;
  logic                      pe_result_valid;

  modport slave (
    input  req_valid, req_opcode, req_op1, req_op2, req_op3, rsp_ready,
    input  pe_result_out, pe_result_valid,
    output req_ready, rsp_valid, rsp_result, rsp_error,
    output pe_opcode_func, pe_op1, pe_op2, pe_op3, pe_valid_in
  );

  modport master (
    output req_valid, req_opcode, req_op1, req_op2, req_op3, rsp_ready,
    output pe_result_out, pe_result_valid,
    input  req_ready, rsp_valid, rsp_result, rsp_error,
    input  pe_opcode_func, pe_op1, pe_op2, pe_op3, pe_valid_in
  );

endinterface

// File: rtl/pe_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo NumReq. Produces a one-hot grant and its index.
module pe_rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned PtrW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [PtrW-1:0]   ptr_i,
  output logic [NumReq-1:0] grant_o,
  output logic [PtrW-1:0]   grant_idx_o
);

  always_comb begin
    int unsigned idx;
    logic        found;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      idx = 32'(ptr_i) + off;
      if (idx >= NumReq) begin
        idx = idx - NumReq;
      end
      if (!found && req_i[PtrW'(idx)]) begin
        grant_o[PtrW'(idx)] = 1'b1;
        grant_idx_o         = PtrW'(idx);
        found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pe_sched_arbiter.sv
// Shares one pe_core_v2 between NUM_REQ requesters: round-robin accept, one-cycle
// issue pulse, bounded wait for the result (timeout error), then a held response.
module pe_sched_arbiter
  import pe_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  pe_sched_arbiter_if.slave bus,
  output logic              busy
);

  localparam int unsigned     IdxW     = clog2(NUM_REQ);
  localparam int unsigned     CntW     = clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] WaitLast = CntW'(TIMEOUT - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] RspOne = {{(NUM_REQ-1){1'b0}}, 1'b1};

  sched_state_e        state_q;
  logic [IdxW-1:0]     rr_ptr_q;
  logic [IdxW-1:0]     win_idx_q;
  logic [IdxW-1:0]     grant_idx;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0]   opcode_q, op1_q, op2_q, op3_q;
  logic [DATA_W-1:0]   rsp_result_q;
  logic                rsp_error_q;
  logic                pe_valid_q;
  logic                busy_q;
  logic [CntW-1:0]     wait_cnt_q;

  logic [DATA_W-1:0] opcode_arr [NUM_REQ];
  logic [DATA_W-1:0] op1_arr    [NUM_REQ];
  logic [DATA_W-1:0] op2_arr    [NUM_REQ];
  logic [DATA_W-1:0] op3_arr    [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign opcode_arr[g] = bus.req_opcode[g*DATA_W +: DATA_W];
    assign op1_arr[g]    = bus.req_op1[g*DATA_W +: DATA_W];
    assign op2_arr[g]    = bus.req_op2[g*DATA_W +: DATA_W];
    assign op3_arr[g]    = bus.req_op3[g*DATA_W +: DATA_W];
  end

  pe_rr_arbiter #(
    .NumReq (NUM_REQ),
    .PtrW   (IdxW)
  ) u_rr_arbiter (
    .req_i       (bus.req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      win_idx_q    <= '0;
      opcode_q     <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      op3_q        <= '0;
      wait_cnt_q   <= '0;
      rsp_result_q <= '0;
      rsp_error_q  <= 1'b0;
      rsp_valid_q  <= '0;
      pe_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      pe_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (|bus.req_valid) begin
            opcode_q   <= opcode_arr[grant_idx];
            op1_q      <= op1_arr[grant_idx];
            op2_q      <= op2_arr[grant_idx];
            op3_q      <= op3_arr[grant_idx];
            win_idx_q  <= grant_idx;
            pe_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          // A result landing on the timeout cycle still wins over the error.
          if (bus.pe_result_valid) begin
            rsp_result_q <= bus.pe_result_out;
            rsp_error_q  <= 1'b0;
            rsp_valid_q  <= RspOne << win_idx_q;
            state_q      <= StResp;
          end else if (wait_cnt_q == WaitLast) begin
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b1;
            rsp_valid_q  <= RspOne << win_idx_q;
            state_q      <= StResp;
          end else if (wait_cnt_q != '1) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StResp: begin
          if (bus.rsp_ready[win_idx_q]) begin
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
            busy_q       <= 1'b0;
            rr_ptr_q     <= (win_idx_q == IdxLast) ? '0 : win_idx_q + 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready      = (state_q == StIdle) ? grant : '0;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_result     = rsp_result_q;
  assign bus.rsp_error      = rsp_error_q;
  assign bus.pe_opcode_func = opcode_q;
  assign bus.pe_op1         = op1_q;
  assign bus.pe_op2         = op2_q;
  assign bus.pe_op3         = op3_q;
  assign bus.pe_valid_in    = pe_valid_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_pe_sched_arbiter.sv
// Bench for pe_sched_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level round-robin/PE reference model.
module tb_pe_sched_arbiter;
  import pe_sched_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int          TO = 8;
  localparam logic [31:0] OpAdd = 32'(OP_ADD);
  localparam logic [31:0] OpSub = 32'(OP_SUB);
  localparam logic [31:0] OpMul = 32'(OP_MUL);

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] opc;
    logic [31:0] op1b;
    logic [31:0] op2;
    logic [31:0] op3;
    int          lat;
    logic [3:0]  exp_rdy;
    logic [31:0] exp_res;
    logic        exp_err;
    int          exp_edges;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        busy;
  int          n_tests;
  int          n_fail;
  int          pe_lat_cfg;
  int          pe_cnt;
  logic        pe_m_valid;
  logic [31:0] pe_m_data;
  logic        stray_valid;
  logic [31:0] stray_data;
  vec_t        tbl [11];

  pe_sched_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  pe_sched_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.pe_result_valid = pe_m_valid | stray_valid;
  assign bus.pe_result_out   = stray_valid ? stray_data : pe_m_data;

  function automatic logic [31:0] pe_fn(input logic [31:0] opc, a, b, c);
    if (opc == OpAdd) return a + b;
    if (opc == OpSub) return a - b;
    if (opc == OpMul) return a * b;
    return a ^ b ^ c;
  endfunction

  function automatic int rr_pick(input logic [3:0] v, input int ptr);
    for (int off = 0; off < N; off++) begin
      if (v[(ptr + off) % N]) return (ptr + off) % N;
    end
    return -1;
  endfunction

  // PE model: answers pe_lat_cfg cycles after the issue pulse (0 = never), reading
  // the operands only when it answers so that unheld operands corrupt the result.
  always @(negedge clk) begin
    if (!rst_n) begin
      pe_cnt     <= 0;
      pe_m_valid <= 1'b0;
      pe_m_data  <= '0;
    end else if (bus.pe_valid_in) begin
      pe_cnt     <= pe_lat_cfg;
      pe_m_valid <= 1'b0;
    end else if (pe_cnt == 1) begin
      pe_cnt     <= 0;
      pe_m_valid <= 1'b1;
      pe_m_data  <= pe_fn(bus.pe_opcode_func, bus.pe_op1, bus.pe_op2, bus.pe_op3);
    end else begin
      pe_m_valid <= 1'b0;
      if (pe_cnt > 1) pe_cnt <= pe_cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // One full transaction: present requests, accept, wait for the response, hold
  // rsp_ready low for rdy_delay cycles (poking non-winner readies), then handshake.
  task automatic do_txn(input logic [3:0] valid, input logic [31:0] opc, op1b, op2, op3,
                        input int lat, input int rdy_delay, input logic [3:0] busy_valid,
                        output logic [3:0] rdy_seen, output logic [3:0] rv,
                        output logic [31:0] res, output logic err, output int edges,
                        output int pv_cnt, output logic stable);
    logic [31:0] p0, p1, p2, p3;
    @(negedge clk);
    bus.req_valid = valid;
    for (int i = 0; i < N; i++) begin
      bus.req_opcode[i*DW +: DW] = opc;
      bus.req_op1[i*DW +: DW]    = op1b + 32'(i);
      bus.req_op2[i*DW +: DW]    = op2;
      bus.req_op3[i*DW +: DW]    = op3;
    end
    pe_lat_cfg = lat;
    #1 rdy_seen = bus.req_ready;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = busy_valid;
    p0 = bus.pe_opcode_func;
    p1 = bus.pe_op1;
    p2 = bus.pe_op2;
    p3 = bus.pe_op3;
    pv_cnt = 0;
    edges  = 0;
    stable = 1'b1;
    while (!(|bus.rsp_valid) && edges < 40) begin
      if (bus.pe_valid_in) pv_cnt++;
      if (bus.req_ready !== 4'b0) stable = 1'b0;
      if (bus.pe_opcode_func !== p0 || bus.pe_op1 !== p1 || bus.pe_op2 !== p2 ||
          bus.pe_op3 !== p3) stable = 1'b0;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    rv  = bus.rsp_valid;
    res = bus.rsp_result;
    err = bus.rsp_error;
    for (int c = 0; c < rdy_delay; c++) begin
      bus.rsp_ready = ~rv & 4'($urandom_range(0, 15));
      @(posedge clk);
      @(negedge clk);
      if (bus.rsp_valid !== rv || bus.rsp_result !== res || bus.rsp_error !== err ||
          bus.req_ready !== 4'b0 || bus.pe_op1 !== p1 || busy !== 1'b1) stable = 1'b0;
    end
    bus.rsp_ready = rv;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = '0;
    bus.req_valid = '0;
    chk("busy_after_handshake", 64'(busy), 64'd0);
    chk("rsp_valid_after_handshake", 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [3:0]  rdy, rv, oh, bv, vmask;
    logic [31:0] res, exp_res, opc, a, b, c;
    logic        err, stable, tmo;
    int          edges, pv, ptr_m, w, lat, rd;

    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    pe_lat_cfg  = 0;
    stray_valid = 1'b0;
    stray_data  = '0;
    bus.req_valid  = '0;
    bus.req_opcode = '0;
    bus.req_op1    = '0;
    bus.req_op2    = '0;
    bus.req_op3    = '0;
    bus.rsp_ready  = '0;

    tbl[0]  = '{4'b1111, OpAdd, 32'd0,  32'd100, 32'd0, 1, 4'b0001, 32'd100, 1'b0, 2};
    tbl[1]  = '{4'b1111, OpAdd, 32'd0,  32'd100, 32'd0, 1, 4'b0010, 32'd101, 1'b0, 2};
    tbl[2]  = '{4'b1111, OpAdd, 32'd0,  32'd100, 32'd0, 1, 4'b0100, 32'd102, 1'b0, 2};
    tbl[3]  = '{4'b1111, OpAdd, 32'd0,  32'd100, 32'd0, 1, 4'b1000, 32'd103, 1'b0, 2};
    tbl[4]  = '{4'b1111, OpAdd, 32'd0,  32'd100, 32'd0, 1, 4'b0001, 32'd100, 1'b0, 2};
    tbl[5]  = '{4'b0101, OpSub, 32'd50, 32'd2,   32'd0, 3, 4'b0100, 32'd50,  1'b0, 4};
    tbl[6]  = '{4'b0101, OpSub, 32'd50, 32'd2,   32'd0, 1, 4'b0001, 32'd48,  1'b0, 2};
    tbl[7]  = '{4'b1000, OpMul, 32'd6,  32'd7,   32'd0, 8, 4'b1000, 32'd63,  1'b0, 9};
    tbl[8]  = '{4'b0010, OpAdd, 32'd1,  32'd3,   32'd0, 0, 4'b0010, 32'd0,   1'b1, 9};
    tbl[9]  = '{4'b0011, OpAdd, 32'd5,  32'd5,   32'd0, 9, 4'b0001, 32'd0,   1'b1, 9};
    tbl[10] = '{4'b1110, OpMul, 32'd3,  32'd16,  32'd0, 2, 4'b0010, 32'd64,  1'b0, 3};

    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_pe_valid", 64'(bus.pe_valid_in), 64'd0);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_pe_op1", 64'(bus.pe_op1), 64'd0);
    chk("reset_rsp_result", 64'(bus.rsp_result), 64'd0);
    rst_n = 1'b1;

    for (int r = 0; r < 11; r++) begin
      do_txn(tbl[r].valid, tbl[r].opc, tbl[r].op1b, tbl[r].op2, tbl[r].op3, tbl[r].lat,
             0, 4'b0000, rdy, rv, res, err, edges, pv, stable);
      chk($sformatf("vec%0d_req_ready", r), 64'(rdy), 64'(tbl[r].exp_rdy));
      chk($sformatf("vec%0d_rsp_valid", r), 64'(rv), 64'(tbl[r].exp_rdy));
      chk($sformatf("vec%0d_result", r), 64'(res), 64'(tbl[r].exp_res));
      chk($sformatf("vec%0d_error", r), 64'(err), 64'(tbl[r].exp_err));
      chk($sformatf("vec%0d_latency", r), 64'(edges), 64'(tbl[r].exp_edges));
      chk($sformatf("vec%0d_pe_valid_cycles", r), 64'(pv), 64'd1);
      chk($sformatf("vec%0d_hold", r), 64'(stable), 64'd1);
    end

    // Single ADD from requester 0 (pointer now at 2, only req0 valid).
    do_txn(4'b0001, OpAdd, 32'd10, 32'd20, 32'd0, 2, 0, 4'b0000,
           rdy, rv, res, err, edges, pv, stable);
    chk("add_grant", 64'(rdy), 64'b0001);
    chk("add_rsp_valid", 64'(rv), 64'b0001);
    chk("add_result", 64'(res), 64'd30);
    chk("add_error", 64'(err), 64'd0);
    chk("add_pe_valid_cycles", 64'(pv), 64'd1);
    chk("add_operand_hold", 64'(stable), 64'd1);

    // Backpressure on requester 1 while the others keep requesting.
    do_txn(4'b0010, OpSub, 32'd100, 32'd1, 32'd0, 1, 5, 4'b1101,
           rdy, rv, res, err, edges, pv, stable);
    chk("bp_grant", 64'(rdy), 64'b0010);
    chk("bp_result", 64'(res), 64'd100);
    chk("bp_stable", 64'(stable), 64'd1);
    do_txn(4'b1101, OpAdd, 32'd0, 32'd0, 32'd0, 1, 0, 4'b0000,
           rdy, rv, res, err, edges, pv, stable);
    chk("bp_next_grant", 64'(rdy), 64'b0100);
    chk("bp_next_result", 64'(res), 64'd2);

    // Stray result pulse while idle.
    @(negedge clk);
    stray_valid = 1'b1;
    stray_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    stray_valid = 1'b0;
    chk("stray_busy", 64'(busy), 64'd0);
    chk("stray_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("stray_pe_valid", 64'(bus.pe_valid_in), 64'd0);

    // Timeout whose late result lands in IDLE afterwards.
    do_txn(4'b1000, OpAdd, 32'd1, 32'd1, 32'd0, 10, 0, 4'b0000,
           rdy, rv, res, err, edges, pv, stable);
    chk("tmo_rsp_valid", 64'(rv), 64'b1000);
    chk("tmo_error", 64'(err), 64'd1);
    chk("tmo_result", 64'(res), 64'd0);
    chk("tmo_latency", 64'(edges), 64'(TO + 1));
    @(negedge clk);
    chk("late_result_busy", 64'(busy), 64'd0);
    chk("late_result_rsp_valid", 64'(bus.rsp_valid), 64'd0);

    // Reset asserted while waiting for the PE.
    @(negedge clk);
    bus.req_valid = 4'b1000;
    bus.req_op1[3*DW +: DW] = 32'h55;
    pe_lat_cfg = 0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    chk("mid_wait_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_pe_op1", 64'(bus.pe_op1), 64'd0);
    chk("arst_pe_opcode", 64'(bus.pe_opcode_func), 64'd0);
    chk("arst_pe_valid", 64'(bus.pe_valid_in), 64'd0);
    chk("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 4'b1111;
    #1 chk("arst_rr_ptr", 64'(bus.req_ready), 64'b0001);
    bus.req_valid = '0;
    do_txn(4'b0100, OpAdd, 32'd7, 32'd8, 32'd0, 2, 0, 4'b0000,
           rdy, rv, res, err, edges, pv, stable);
    chk("post_rst_grant", 64'(rdy), 64'b0100);
    chk("post_rst_result", 64'(res), 64'd17);

    // Randomized transactions against the reference model.
    ptr_m = 3;
    for (int it = 0; it < 40; it++) begin
      vmask = 4'($urandom_range(1, 15));
      case ($urandom_range(0, 3))
        0: opc = OpAdd;
        1: opc = OpSub;
        2: opc = OpMul;
        default: opc = 32'h0000_0FFF;
      endcase
      a   = $urandom;
      b   = $urandom;
      c   = $urandom;
      lat = $urandom_range(0, 10);
      rd  = $urandom_range(0, 3);
      bv  = 4'($urandom_range(0, 15));
      w   = rr_pick(vmask, ptr_m);
      oh  = 4'b0001 << w;
      tmo = (lat == 0) || (lat > TO);
      exp_res = tmo ? 32'd0 : pe_fn(opc, a + 32'(w), b, c);
      do_txn(vmask, opc, a, b, c, lat, rd, bv, rdy, rv, res, err, edges, pv, stable);
      chk($sformatf("rnd%0d_req_ready", it), 64'(rdy), 64'(oh));
      chk($sformatf("rnd%0d_rsp_valid", it), 64'(rv), 64'(oh));
      chk($sformatf("rnd%0d_result", it), 64'(res), 64'(exp_res));
      chk($sformatf("rnd%0d_error", it), 64'(err), 64'(tmo));
      chk($sformatf("rnd%0d_latency", it), 64'(edges), 64'(tmo ? TO + 1 : lat + 1));
      chk($sformatf("rnd%0d_hold", it), 64'(stable), 64'd1);
      ptr_m = (w + 1) % N;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
